// File: rtl/dlc_ff_pipe.sv
// Valid-qualified register pipeline with stall, flush and occupancy tracking.
// Define DLC_FF_PIPE_PARITY_EN to add the end-to-end parity check and the sticky par_err flag.
module dlc_ff_pipe #(
    parameter int unsigned        WIDTH = 1,
    parameter int unsigned        DEPTH = 2,
    parameter logic [WIDTH-1:0]   RSTV  = '0,
    localparam int unsigned       CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             par_inj,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    occupancy,
    output logic             par_err
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [CW-1:0]    occ_q, occ_d;

    // Occupancy tracks popcount(vld_q) incrementally: one word in, one word out per shift.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (enable) begin
            occ_d = occ_q + CW'(din_valid) - CW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RSTV;
            end
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            if (enable) begin
                data_q[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end
            if (flush) begin
                vld_q <= '0;
            end else if (enable) begin
                vld_q <= DEPTH'({vld_q, din_valid});
            end
            occ_q <= occ_d;
        end
    end

    assign dout       = data_q[DEPTH-1];
    assign dout_valid = vld_q[DEPTH-1];
    assign occupancy  = occ_q;

`ifdef DLC_FF_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             par_err_q;

    // Parity bits shift alongside the data; flush only drops valids, so parity is untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q     <= {DEPTH{^RSTV}};
            par_err_q <= 1'b0;
        end else begin
            if (enable) begin
                par_q <= DEPTH'({par_q, (^din) ^ par_inj});
            end
            if (dout_valid && ((^dout) != par_q[DEPTH-1])) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign par_err = par_err_q;
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_dlc_ff_pipe.sv
// Self-checking bench for dlc_ff_pipe: a queue-based reference model checked every cycle,
// plus directed literal checks. Two instances: DEPTH=3 (main) and DEPTH=1 (bubbles).
module tb_dlc_ff_pipe;

`ifdef DLC_FF_PIPE_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam logic [7:0] RSTV_A = 8'hA5;
    localparam logic [7:0] RSTV_B = 8'h5A;

    logic       clk = 1'b0;
    logic       reset = 1'b1, enable = 1'b0, flush = 1'b0, din_valid = 1'b0, par_inj = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b, pe_a, pe_b;
    logic [1:0] occ_a;
    logic [0:0] occ_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dlc_ff_pipe #(.WIDTH(8), .DEPTH(3), .RSTV(RSTV_A)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .din(din),
        .din_valid(din_valid), .par_inj(par_inj), .dout(dout_a), .dout_valid(dv_a),
        .occupancy(occ_a), .par_err(pe_a)
    );

    dlc_ff_pipe #(.WIDTH(8), .DEPTH(1), .RSTV(RSTV_B)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .din(din),
        .din_valid(din_valid), .par_inj(par_inj), .dout(dout_b), .dout_valid(dv_b),
        .occupancy(occ_b), .par_err(pe_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each queue entry is {parity, valid, data}, index 0 = newest stage.
    typedef logic [9:0] ent_t;
    ent_t qa[$];
    ent_t qb[$];
    bit   m_ok = 1'b0;
    bit   mpe_a, mpe_b;

    always @(posedge clk) begin
        if (reset) begin
            qa = {};
            qb = {};
            repeat (3) qa.push_back({^RSTV_A, 1'b0, RSTV_A});
            qb.push_back({^RSTV_B, 1'b0, RSTV_B});
            mpe_a = 1'b0;
            mpe_b = 1'b0;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            if (PAR && qa[2][8] && ((^qa[2][7:0]) != qa[2][9])) mpe_a = 1'b1;
            if (PAR && qb[0][8] && ((^qb[0][7:0]) != qb[0][9])) mpe_b = 1'b1;
            if (enable) begin
                qa.push_front({(^din) ^ par_inj, din_valid, din});
                qb.push_front({(^din) ^ par_inj, din_valid, din});
                void'(qa.pop_back());
                void'(qb.pop_back());
            end
            if (flush) begin
                foreach (qa[i]) qa[i][8] = 1'b0;
                foreach (qb[i]) qb[i][8] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            int na;
            int nb;
            na = 0;
            nb = 0;
            foreach (qa[i]) na += int'(qa[i][8]);
            foreach (qb[i]) nb += int'(qb[i][8]);
            chk("model_dout_a", 32'(dout_a), 32'(qa[2][7:0]));
            chk("model_dv_a",   32'(dv_a),   32'(qa[2][8]));
            chk("model_occ_a",  32'(occ_a),  32'(na));
            chk("model_pe_a",   32'(pe_a),   32'(mpe_a));
            chk("model_dout_b", 32'(dout_b), 32'(qb[0][7:0]));
            chk("model_dv_b",   32'(dv_b),   32'(qb[0][8]));
            chk("model_occ_b",  32'(occ_b),  32'(nb));
            chk("model_pe_b",   32'(pe_b),   32'(mpe_b));
        end
    end

    // Drive one clock's worth of inputs, then return after that edge has taken effect.
    task automatic cyc(input logic r, input logic f, input logic e, input logic [7:0] d,
                       input logic v, input logic pi);
        reset     = r;
        flush     = f;
        enable    = e;
        din       = d;
        din_valid = v;
        par_inj   = pi;
        @(negedge clk);
    endtask

    initial begin
        // Reset and latency
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_dout", 32'(dout_a), 32'hA5);
        chk("rst_occ", 32'(occ_a), 32'd0);
        chk("rst_dv", 32'(dv_a), 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        chk("rst_over_en_dout", 32'(dout_a), 32'hA5);
        chk("rst_over_en_occ", 32'(occ_a), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
        chk("lat_occ1", 32'(occ_a), 32'd1);
        chk("lat_dv0", 32'(dv_a), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0);
        chk("lat_occ2", 32'(occ_a), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        chk("lat_occ3", 32'(occ_a), 32'd3);
        chk("lat_dout11", 32'(dout_a), 32'h11);
        chk("lat_dv1", 32'(dv_a), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0);
        chk("lat_occ3b", 32'(occ_a), 32'd3);
        chk("lat_dout22", 32'(dout_a), 32'h22);

        // Stall
        repeat (5) begin
            cyc(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0);
            chk("stall_dout", 32'(dout_a), 32'h22);
            chk("stall_occ", 32'(occ_a), 32'd3);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("drain_dout33", 32'(dout_a), 32'h33);
        chk("drain_occ2", 32'(occ_a), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("drain_dout44", 32'(dout_a), 32'h44);
        chk("drain_occ1", 32'(occ_a), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("drain_dv0", 32'(dv_a), 32'd0);
        chk("drain_occ0", 32'(occ_a), 32'd0);

        // Flush with enable and valid input
        cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("pre_flush_occ", 32'(occ_a), 32'd3);
        cyc(1'b0, 1'b1, 1'b1, 8'h88, 1'b1, 1'b0);
        chk("flush_occ", 32'(occ_a), 32'd0);
        chk("flush_dv", 32'(dv_a), 32'd0);
        chk("flush_dout_shift", 32'(dout_a), 32'h66);
        cyc(1'b0, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
        chk("post_flush_occ1", 32'(occ_a), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_flush_dout88", 32'(dout_a), 32'h88);
        chk("post_flush_dv0", 32'(dv_a), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_flush_dout99", 32'(dout_a), 32'h99);
        chk("post_flush_dv1", 32'(dv_a), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_flush_empty", 32'(occ_a), 32'd0);

        // Reset mid-stream during a stall
        cyc(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
        chk("mid_occ2", 32'(occ_a), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_rst_occ", 32'(occ_a), 32'd0);
        chk("mid_rst_dout", 32'(dout_a), 32'hA5);
        chk("mid_rst_dv", 32'(dv_a), 32'd0);

        // Parity injection on a valid word
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("par_at_dout", 32'(dout_a), 32'h3C);
        chk("par_not_yet", 32'(pe_a), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("par_set", 32'(pe_a), 32'(PAR));
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("par_sticky", 32'(pe_a), 32'(PAR));
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("par_rst", 32'(pe_a), 32'd0);
        // Injection on an invalid word must stay silent
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("par_inv_quiet", 32'(pe_a), 32'd0);

        // Bubbles through the single-stage instance
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'(i + 1), (i % 2) == 0, 1'b0);
            chk("bub_dv", 32'(dv_b), 32'((i % 2) == 0));
            chk("bub_occ", 32'(occ_b), 32'((i % 2) == 0));
            chk("bub_dout", 32'(dout_b), 32'(i + 1));
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bub_flush_occ", 32'(occ_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule
